// File: rtl/motor_ramp_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : motor_ramp_sequencer_if
//  Description : Command handshake and drive-output bundle between a command
//                source (master) and the motor ramp sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface motor_ramp_sequencer_if;
    // Command channel
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_duty;
    logic [1:0] cmd_dir;
    logic       estop;

    // Drive and status outputs
    logic [3:0] duty_out;
    logic [1:0] dir_out;
    logic       busy;
    logic [1:0] state_out;

    modport master (
        output cmd_valid, cmd_duty, cmd_dir, estop,
        input  cmd_ready, duty_out, dir_out, busy, state_out
    );

    modport slave (
        input  cmd_valid, cmd_duty, cmd_dir, estop,
        output cmd_ready, duty_out, dir_out, busy, state_out
    );
endinterface
`default_nettype wire

// File: rtl/motor_ramp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : motor_ramp_sequencer
//  Description : Soft-start / soft-stop sequencer for an H-bridge motor. Ramps
//                the duty step one unit every RAMP_DIV cycles toward a commanded
//                target, inserts a DEAD_CYC off period before any reversal or
//                stop, and supports a level-sensitive emergency stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_ramp_sequencer #(
    parameter int RAMP_DIV = 10_000_000,
    parameter int DEAD_CYC = 20_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    motor_ramp_sequencer_if.slave  bus
);

    // Counter widths, never narrower than one bit
    localparam int c_PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int c_DEAD_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(RAMP_DIV - 1);
    localparam logic [c_DEAD_W-1:0]  c_DEAD_LAST  = c_DEAD_W'(DEAD_CYC - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [c_DEAD_W-1:0]  c_DEAD_ONE   = c_DEAD_W'(1);

    localparam logic [3:0] c_DUTY_MAX = 4'd9;
    localparam logic [1:0] c_DIR_OFF  = 2'b00;
    localparam logic [1:0] c_DIR_FWD  = 2'b01;
    localparam logic [1:0] c_DIR_REV  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RAMP = 2'b01,
        S_DEAD = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    // Registered state
    state_t                 r_state;
    logic [3:0]             r_duty;
    logic [1:0]             r_dir;
    logic [3:0]             r_tgt_duty;
    logic [1:0]             r_tgt_dir;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [c_DEAD_W-1:0]    r_dead;

    // Next-state values
    state_t                 w_state_nxt;
    logic [3:0]             w_duty_nxt;
    logic [1:0]             w_dir_nxt;
    logic [3:0]             w_tgt_duty_nxt;
    logic [1:0]             w_tgt_dir_nxt;
    logic [c_PRESC_W-1:0]   w_presc_nxt;
    logic [c_DEAD_W-1:0]    w_dead_nxt;

    // Decoded command and ramp helpers
    logic                   w_cmd_ready;
    logic                   w_accept;
    logic [3:0]             w_cmd_duty;
    logic [1:0]             w_cmd_dir;
    logic [3:0]             w_eff_tgt;
    logic [3:0]             w_step_duty;

    // Ready only in the settled states and never during an emergency stop
    assign w_cmd_ready = ((r_state == S_IDLE) || (r_state == S_HOLD)) && !bus.estop;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;

    // Clamp the requested duty; a zero duty or a non-drive code means "stop"
    assign w_cmd_duty = (bus.cmd_duty > c_DUTY_MAX) ? c_DUTY_MAX : bus.cmd_duty;
    assign w_cmd_dir  = (((bus.cmd_dir == c_DIR_FWD) || (bus.cmd_dir == c_DIR_REV))
                         && (w_cmd_duty != 4'd0)) ? bus.cmd_dir : c_DIR_OFF;

    // While the bridge points the wrong way, ramp toward zero first
    assign w_eff_tgt   = (r_tgt_dir != r_dir) ? 4'd0 : r_tgt_duty;
    assign w_step_duty = (r_duty < w_eff_tgt) ? (r_duty + 4'd1) :
                         (r_duty > w_eff_tgt) ? (r_duty - 4'd1) : r_duty;

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_duty     <= 4'd0;
            r_dir      <= c_DIR_OFF;
            r_tgt_duty <= 4'd0;
            r_tgt_dir  <= c_DIR_OFF;
            r_presc    <= '0;
            r_dead     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_dir      <= w_dir_nxt;
            r_tgt_duty <= w_tgt_duty_nxt;
            r_tgt_dir  <= w_tgt_dir_nxt;
            r_presc    <= w_presc_nxt;
            r_dead     <= w_dead_nxt;
        end
    end

    // Next-state, ramp stepping and dead-time sequencing
    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_dir_nxt      = r_dir;
        w_tgt_duty_nxt = r_tgt_duty;
        w_tgt_dir_nxt  = r_tgt_dir;
        w_presc_nxt    = r_presc;
        w_dead_nxt     = r_dead;

        if (bus.estop) begin
            w_state_nxt    = S_IDLE;
            w_duty_nxt     = 4'd0;
            w_dir_nxt      = c_DIR_OFF;
            w_tgt_duty_nxt = 4'd0;
            w_tgt_dir_nxt  = c_DIR_OFF;
            w_presc_nxt    = '0;
            w_dead_nxt     = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // A stop request while already stopped is a no-op; a drive
                    // request needs no dead time because the bridge is off
                    if (w_accept && (w_cmd_dir != c_DIR_OFF)) begin
                        w_tgt_duty_nxt = w_cmd_duty;
                        w_tgt_dir_nxt  = w_cmd_dir;
                        w_dir_nxt      = w_cmd_dir;
                        w_presc_nxt    = '0;
                        w_state_nxt    = S_RAMP;
                    end
                end

                S_HOLD: begin
                    if (w_accept && !((w_cmd_dir == r_dir) && (w_cmd_duty == r_duty))) begin
                        w_tgt_duty_nxt = w_cmd_duty;
                        w_tgt_dir_nxt  = w_cmd_dir;
                        w_presc_nxt    = '0;
                        w_state_nxt    = S_RAMP;
                    end
                end

                S_RAMP: begin
                    if (r_presc == c_PRESC_LAST) begin
                        w_presc_nxt = '0;
                        w_duty_nxt  = w_step_duty;
                        if ((r_tgt_dir == r_dir) && (w_step_duty == r_tgt_duty)) begin
                            w_state_nxt = S_HOLD;
                        end else if ((r_tgt_dir != r_dir) && (w_step_duty == 4'd0)) begin
                            // Fully spun down: release the bridge before reversing
                            w_dir_nxt   = c_DIR_OFF;
                            w_dead_nxt  = '0;
                            w_state_nxt = S_DEAD;
                        end
                    end else begin
                        w_presc_nxt = r_presc + c_PRESC_ONE;
                    end
                end

                S_DEAD: begin
                    if (r_dead == c_DEAD_LAST) begin
                        w_dead_nxt = '0;
                        if (r_tgt_dir == c_DIR_OFF) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_dir_nxt   = r_tgt_dir;
                            w_presc_nxt = '0;
                            w_state_nxt = S_RAMP;
                        end
                    end else begin
                        w_dead_nxt = r_dead + c_DEAD_ONE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.duty_out  = r_duty;
    assign bus.dir_out   = r_dir;
    assign bus.busy      = (r_state == S_RAMP) || (r_state == S_DEAD);
    assign bus.state_out = r_state;

endmodule
`default_nettype wire
